// File: rtl/ecpu_bus_pkg.sv
// Shared Wishbone bus types and helpers for the ecpu memory arbiters.
package ecpu_bus_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    // Master-to-slave request bundle.
    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

    // Slave-to-master response bundle.
    typedef struct packed {
        logic                 ack;
        logic                 err;
        logic [WB_DATA_W-1:0] dat;
    } wb_rsp_t;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Counter width able to hold 0..t, never narrower than one bit.
    function automatic int wd_cnt_width(input int t);
        return ($clog2(t + 1) < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive cycles a strobe is active without
// progress (ack/err) and fires a single-cycle pulse after TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables it (fire tied low).
module wb_watchdog
    import ecpu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active,
    input  logic progress,
    output logic fire
);

    localparam int CNT_W = wd_cnt_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] wd_cnt;

            // Fire on the last allowed stalled cycle; the pulse itself clears the count.
            assign fire = active && !progress && (wd_cnt == LAST);

            // Count stalled strobe cycles; any progress, idle strobe or fire restarts.
            always_ff @(posedge clk_i) begin
                if (rst_i || !active || progress || fire) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
            end
        end else begin : g_off
            logic unused_wd;
            assign unused_wd = ^{clk_i, rst_i, active, progress};
            assign fire      = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/imem_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the instruction memory.
// Master 0 is the fetch unit, master 1 the debug/program loader.
// Ownership is registered and held for the whole bus cycle (cyc high);
// arbitration costs one idle cycle between owners.
// Handshake: the owner's cyc/stb/we/adr/dat/sel pass straight to the slave;
// a transfer completes in any cycle where stb and ack (or err) are both high.
// The non-owner sees ack/err/dat held at 0 and simply waits.
module imem_wb_arbiter
    import ecpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       last_grant;       // 0 = master 0 owned last, 1 = master 1
    logic       last_grant_nxt;
    logic       wd_active;
    logic       wd_progress;
    logic       wd_fire;

    // State and fairness registers; reset favours master 0 on the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Arbitration in IDLE, release to IDLE when the owner drops cyc.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if ((ROUND_ROBIN != 0) && !last_grant) begin
                        state_nxt      = OWN1;
                        last_grant_nxt = 1'b1;
                    end else begin
                        state_nxt      = OWN0;
                        last_grant_nxt = 1'b0;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt      = OWN0;
                    last_grant_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt      = OWN1;
                    last_grant_nxt = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) state_nxt = IDLE;
            end
            OWN1: begin
                if (!m1_cyc_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog watches the owner's strobe; ack or err counts as progress.
    assign wd_active   = ((state == OWN0) && m0_stb_i) || ((state == OWN1) && m1_stb_i);
    assign wd_progress = s_ack_i || s_err_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .active   (wd_active),
        .progress (wd_progress),
        .fire     (wd_fire)
    );

    // Request/response mux; a watchdog fire withdraws stb and errors the owner.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;
        unique case (state)
            OWN0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i && !wd_fire;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i || wd_fire;
                m0_dat_o  = s_dat_i;
                grant_o   = 2'b01;
                timeout_o = wd_fire;
            end
            OWN1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i && !wd_fire;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i || wd_fire;
                m1_dat_o  = s_dat_i;
                grant_o   = 2'b10;
                timeout_o = wd_fire;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_imem_wb_arbiter.sv
// Bench for imem_wb_arbiter: two instances (round-robin with a 4-cycle
// watchdog, fixed-priority with the watchdog off) share master stimulus,
// each behind its own combinational memory slave. A reference model of
// ownership is checked against both every cycle; directed scenarios pin
// literal values.
module tb_imem_wb_arbiter;

    localparam int N = 2;

    int rr_p [N] = '{1, 0};
    int to_p [N] = '{4, 0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_dat = 0;
    logic [3:0]  m0_sel = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_dat = 0;
    logic [3:0]  m1_sel = 0;
    logic        rdy = 0, errq = 0;

    // ---------------- DUT outputs / slave side ----------------
    logic [N-1:0] s_cyc, s_stb, s_we, s_ack, s_err, gstb;
    logic [31:0]  s_adr [N];
    logic [31:0]  s_dato [N];
    logic [31:0]  s_dati [N];
    logic [3:0]   s_sel [N];
    logic [N-1:0] m0_ack, m0_err, m1_ack, m1_err, tout;
    logic [31:0]  m0_dato [N];
    logic [31:0]  m1_dato [N];
    logic [1:0]   grant [N];

    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        mem[2] = 32'h0050_0093;
    end

    // Combinational memory slave per instance: answers the granted master's strobe.
    for (genvar k = 0; k < N; k++) begin : g_slv
        assign gstb[k]   = grant[k][0] ? m0_stb : (grant[k][1] ? m1_stb : 1'b0);
        assign s_ack[k]  = s_cyc[k] & gstb[k] & rdy;
        assign s_err[k]  = s_cyc[k] & gstb[k] & errq;
        assign s_dati[k] = mem[s_adr[k][5:2]];
    end

    imem_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]),
        .m0_dat_o(m0_dato[0]),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]),
        .m1_dat_o(m1_dato[0]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]), .s_adr_o(s_adr[0]),
        .s_dat_o(s_dato[0]), .s_sel_o(s_sel[0]), .s_ack_i(s_ack[0]), .s_err_i(s_err[0]),
        .s_dat_i(s_dati[0]), .grant_o(grant[0]), .timeout_o(tout[0])
    );

    imem_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]),
        .m0_dat_o(m0_dato[1]),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]),
        .m1_dat_o(m1_dato[1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]), .s_adr_o(s_adr[1]),
        .s_dat_o(s_dato[1]), .s_sel_o(s_sel[1]), .s_ack_i(s_ack[1]), .s_err_i(s_err[1]),
        .s_dat_i(s_dati[1]), .grant_o(grant[1]), .timeout_o(tout[1])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit running = 1'b1;

    task automatic chk(input string nm, input int k, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, who won last, how long the owner has stalled.
    int   own [N];     // 0 none, 1 master 0, 2 master 1
    int   last_g [N];  // index of the master granted most recently
    int   wd [N];
    bit   mvalid = 1'b0;

    initial begin
        logic        c, s, w, ai, ei, stall, fire;
        logic [31:0] a, d;
        logic [3:0]  sl;
        logic [1:0]  e_grant;
        logic [31:0] e_rdat;
        forever begin
            @(negedge clk);
            if (running) begin
                for (int k = 0; k < N; k++) begin
                    c = 0; s = 0; w = 0; a = 0; d = 0; sl = 0;
                    ai = 0; ei = 0; stall = 0; fire = 0;
                    if (own[k] == 1) begin
                        c = m0_cyc; s = m0_stb; w = m0_we; a = m0_adr; d = m0_dat; sl = m0_sel;
                    end else if (own[k] == 2) begin
                        c = m1_cyc; s = m1_stb; w = m1_we; a = m1_adr; d = m1_dat; sl = m1_sel;
                    end
                    if (own[k] != 0) begin
                        ai    = c & s & rdy;
                        ei    = c & s & errq;
                        stall = s & !ai & !ei;
                        fire  = (to_p[k] > 0) && stall && (wd[k] == to_p[k] - 1);
                    end
                    e_grant = (own[k] == 1) ? 2'b01 : ((own[k] == 2) ? 2'b10 : 2'b00);
                    e_rdat  = (own[k] != 0) ? mem[a[5:2]] : 32'h0;
                    if (mvalid) begin
                        chk("s_ctl", k, {s_cyc[k], s_stb[k], s_we[k], s_sel[k]}, {c, s & !fire, w, sl});
                        chk("s_adr", k, s_adr[k], a);
                        chk("s_dat", k, s_dato[k], d);
                        chk("grant", k, grant[k], e_grant);
                        chk("timeout", k, tout[k], fire);
                        chk("m0_rsp", k, {m0_ack[k], m0_err[k]},
                            (own[k] == 1) ? {ai, ei | fire} : 2'b00);
                        chk("m0_dat", k, m0_dato[k], (own[k] == 1) ? e_rdat : 32'h0);
                        chk("m1_rsp", k, {m1_ack[k], m1_err[k]},
                            (own[k] == 2) ? {ai, ei | fire} : 2'b00);
                        chk("m1_dat", k, m1_dato[k], (own[k] == 2) ? e_rdat : 32'h0);
                    end
                    // Advance the model across the coming clock edge.
                    if (rst) begin
                        own[k] = 0; last_g[k] = 1; wd[k] = 0;
                    end else if (own[k] == 0) begin
                        wd[k] = 0;
                        if (m0_cyc && m1_cyc) own[k] = (rr_p[k] != 0 && last_g[k] == 0) ? 2 : 1;
                        else if (m0_cyc)      own[k] = 1;
                        else if (m1_cyc)      own[k] = 2;
                        if (own[k] != 0) last_g[k] = own[k] - 1;
                    end else if (!c) begin
                        own[k] = 0; wd[k] = 0;
                    end else begin
                        wd[k] = (stall && !fire) ? wd[k] + 1 : 0;
                    end
                end
                if (rst) mvalid = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic clear_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
        rdy = 0; errq = 0;
    endtask

    // Ends in the first post-reset cycle (IDLE) with inputs still settable.
    task automatic do_reset();
        tick();
        clear_masters();
        rst = 1;
        tick();
        rst = 0;
    endtask

    logic [1:0] gseq[$];

    task automatic contention(input int wi);
        logic       prev0, prev1;
        logic [1:0] exp_seq [5];
        do_reset();
        gseq.delete();
        prev0 = 0; prev1 = 0;
        for (int i = 0; i < 12; i++) begin
            m0_cyc = !prev0; m0_stb = m0_cyc; m0_adr = 32'h4;
            m1_cyc = !prev1; m1_stb = m1_cyc; m1_adr = 32'h8;
            rdy = 1; errq = 0;
            look();
            prev0 = m0_ack[wi];
            prev1 = m1_ack[wi];
            if (gseq.size() == 0) begin
                if (grant[wi] != 2'b00) gseq.push_back(grant[wi]);
            end else if (grant[wi] != gseq[$]) begin
                gseq.push_back(grant[wi]);
            end
            tick();
        end
        if (wi == 0) exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        else         exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        chk("cont_len", wi, (gseq.size() >= 5), 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("cont_seq", wi, (i < gseq.size()) ? gseq[i] : 2'b11, exp_seq[i]);
        end
        clear_masters();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b_err;
        logic exp_fire;

        // Reset held three cycles with both masters requesting.
        rst = 1; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; rdy = 1;
        repeat (3) begin
            tick();
            look();
            for (int k = 0; k < N; k++) begin
                chk("rst_grant", k, grant[k], 2'b00);
                chk("rst_out", k, {s_cyc[k], s_stb[k], m0_ack[k], m1_ack[k], tout[k]}, 5'b0);
            end
        end
        tick();
        rst = 0;
        look();
        for (int k = 0; k < N; k++) chk("rel_idle", k, grant[k], 2'b00);
        tick();
        look();
        for (int k = 0; k < N; k++) chk("rel_grant", k, grant[k], 2'b01);
        tick(); clear_masters(); tick(); tick();

        // Solo fetch of the word at 0x8.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8; m0_sel = 4'hf; rdy = 1;
        look();
        chk("fetch_c0_grant", 0, grant[0], 2'b00);
        chk("fetch_c0_ack", 0, m0_ack[0], 1'b0);
        tick();
        look();
        for (int k = 0; k < N; k++) begin
            chk("fetch_adr", k, s_adr[k], 32'h8);
            chk("fetch_ack", k, m0_ack[k], 1'b1);
            chk("fetch_dat", k, m0_dato[k], 32'h0050_0093);
            chk("fetch_m1", k, {m1_ack[k], m1_err[k], m1_dato[k]}, 34'h0);
        end

        // Contention seen from each instance in turn.
        contention(0);
        contention(1);

        // Burst lock: four strobes from master 0 while master 1 waits.
        do_reset();
        m0_cyc = 1; m0_stb = 0; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20; rdy = 1;
        look();
        tick();
        for (int i = 0; i < 4; i++) begin
            m0_stb = 1; m0_adr = 32'(i * 4);
            look();
            chk("burst_grant", 0, grant[0], 2'b01);
            chk("burst_ack", 0, m0_ack[0], 1'b1);
            chk("burst_dat", 0, m0_dato[0], mem[i]);
            tick();
        end
        m0_cyc = 0; m0_stb = 0;
        look(); chk("burst_drop", 0, grant[0], 2'b01);
        tick(); look(); chk("burst_gap", 0, grant[0], 2'b00);
        tick(); look(); chk("burst_m1", 0, grant[0], 2'b10);
        tick();

        // Watchdog: master 1 stalls against a silent slave.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hc; rdy = 0; errq = 0;
        look();
        tick();
        for (int i = 1; i <= 5; i++) begin
            exp_fire = (i == 4);
            look();
            chk("wd_err", 0, m1_err[0], exp_fire);
            chk("wd_tout", 0, tout[0], exp_fire);
            chk("wd_stb", 0, s_stb[0], !exp_fire);
            tick();
        end
        b_err = 0;
        for (int i = 0; i < 100; i++) begin
            look();
            if (m1_err[1] || tout[1]) b_err++;
            tick();
        end
        chk("wd_off", 1, b_err, 0);

        // Error passthrough on a master 0 write.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0; m0_dat = $urandom; m0_sel = 4'hf;
        rdy = 0; errq = 1;
        look();
        tick();
        look();
        for (int k = 0; k < N; k++) begin
            chk("err_pass", k, {m0_ack[k], m0_err[k], s_we[k]}, 3'b011);
        end

        // Reset while master 1 owns the bus.
        do_reset();
        m1_cyc = 1; m1_stb = 0;
        look();
        tick();
        look();
        chk("mid_own", 0, {grant[0], s_cyc[0]}, 3'b101);
        tick();
        rst = 1;
        look();
        chk("mid_hold", 0, s_cyc[0], 1'b1);
        tick();
        rst = 0;
        look();
        for (int k = 0; k < N; k++) chk("mid_rst", k, {grant[k], s_cyc[k]}, 3'b000);

        // Randomized traffic checked by the model.
        tick();
        clear_masters();
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = ($urandom_range(3) != 0);
            m1_stb = ($urandom_range(3) != 0);
            m0_we  = 1'($urandom_range(1));
            m1_we  = 1'($urandom_range(1));
            m0_adr = 32'($urandom_range(15)) << 2;
            m1_adr = 32'($urandom_range(15)) << 2;
            m0_dat = $urandom;
            m1_dat = $urandom;
            m0_sel = 4'($urandom_range(15));
            m1_sel = 4'($urandom_range(15));
            rdy    = ($urandom_range(2) == 0);
            errq   = ($urandom_range(7) == 0);
            rst    = ($urandom_range(99) == 0);
        end
        tick();
        rst = 0;
        look();
        running = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
